// File: rtl/platform_scroller.sv
// platform_scroller
//   Owns the platform field of the doodle game. Once per frame (rising edge of
//   frame_clk) it latches the ball state, scrolls the field down when the ball
//   is above the scroll line, respawns platforms that fell off the bottom at the
//   top with an LFSR-chosen X, looks for a landing and accumulates the score.
// Ports
//   Clk, Reset     system clock, synchronous active-high reset
//   frame_clk      VGA_VS, synchronous to Clk; rising edge starts an update
//   BallX/Y/S      ball centre and half-size; BallFalling = moving downward
//   DrawX/DrawY    current pixel from the VGA controller
//   PlatPixel      registered: previous cycle's pixel lies on a platform
//   Land/LandY     one-cycle landing pulse and top Y of the platform hit
//   ScrollAmt      scroll applied by the last update
//   Score          cumulative scroll, saturating
//   Busy           update in progress
module platform_scroller #(
  parameter int          NUM_PLAT    = 8,
  parameter int          PLAT_W      = 64,
  parameter int          PLAT_H      = 8,
  parameter int          SCREEN_W    = 640,
  parameter int          SCREEN_H    = 480,
  parameter int          SCROLL_LINE = 160,
  parameter int          MAX_SCROLL  = 16,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic [9:0]  BallX,
  input  logic [9:0]  BallY,
  input  logic [9:0]  BallS,
  input  logic        BallFalling,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  output logic        PlatPixel,
  output logic        Land,
  output logic [9:0]  LandY,
  output logic [9:0]  ScrollAmt,
  output logic [15:0] Score,
  output logic        Busy
);

  localparam int              KW        = (NUM_PLAT > 1) ? $clog2(NUM_PLAT) : 1;
  localparam logic [KW-1:0]   LAST_K    = KW'(NUM_PLAT - 1);
  localparam int              ROW_PITCH = SCREEN_H / NUM_PLAT;
  localparam logic [9:0]      SCR_H     = 10'(SCREEN_H);
  localparam logic [9:0]      SPAN      = 10'(SCREEN_W - PLAT_W);
  localparam logic [9:0]      LINE      = 10'(SCROLL_LINE);
  localparam logic [9:0]      MAXS      = 10'(MAX_SCROLL);
  localparam logic [10:0]     PW11      = 11'(PLAT_W);
  localparam logic [10:0]     PH11      = 11'(PLAT_H);

  typedef enum logic [2:0] {IDLE, SCROLL, RESPAWN, CHECK, DONE} state_t;

  // Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
  endfunction

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [9:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {7'd0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  state_t          state_r, state_s;
  logic            frame_clk_q_r;
  logic            tick_s;
  logic [KW-1:0]   k_r;
  logic [9:0]      shift_r, shift_s, diff_s;
  logic [9:0]      ball_x_r, ball_y_r, ball_s_r;
  logic            ball_f_r;
  logic [9:0]      py_r [NUM_PLAT];
  logic [9:0]      px_r [NUM_PLAT];
  logic [15:0]     lfsr_r;
  logic [9:0]      rand_x_s;
  logic            hit_r, hit_k_s;
  logic [9:0]      win_y_r;
  logic [10:0]     bot_s, py_k_s, px_k_s, bx_s, bs_s;
  logic            pix_s;
  logic            plat_pixel_r, land_r;
  logic [9:0]      land_y_r, scroll_amt_r;
  logic [15:0]     score_r;

  assign tick_s    = frame_clk & ~frame_clk_q_r;
  assign PlatPixel = plat_pixel_r;
  assign Land      = land_r;
  assign LandY     = land_y_r;
  assign ScrollAmt = scroll_amt_r;
  assign Score     = score_r;
  assign Busy      = (state_r != IDLE);

  // Scroll amount for the frame being latched: distance above the line, clamped.
  always_comb begin
    diff_s  = LINE - BallY;
    shift_s = 10'd0;
    if (BallY < LINE) begin
      shift_s = (diff_s > MAXS) ? MAXS : diff_s;
    end else begin
      shift_s = 10'd0;
    end
  end

  // Fold the raw LFSR value into the legal platform X range.
  always_comb begin
    rand_x_s = lfsr_r[9:0];
    for (int j = 0; j < 2; j++) begin
      if (rand_x_s >= SPAN) begin
        rand_x_s = rand_x_s - SPAN;
      end else begin
        rand_x_s = rand_x_s;
      end
    end
  end

  // Landing test of slot k against the latched ball; all compares 11 bits wide.
  always_comb begin
    bx_s    = {1'b0, ball_x_r};
    bs_s    = {1'b0, ball_s_r};
    bot_s   = {1'b0, ball_y_r} + bs_s;
    py_k_s  = {1'b0, py_r[k_r]};
    px_k_s  = {1'b0, px_r[k_r]};
    hit_k_s = ball_f_r &&
              (py_k_s <= bot_s) && (bot_s < py_k_s + PH11) &&
              (bx_s + bs_s > px_k_s) && (bx_s < px_k_s + PW11 + bs_s);
  end

  // Per-pixel platform coverage from the live slot array.
  always_comb begin
    pix_s = 1'b0;
    for (int i = 0; i < NUM_PLAT; i++) begin
      if ((py_r[i] < SCR_H) &&
          (px_r[i] <= DrawX) && ({1'b0, DrawX} < {1'b0, px_r[i]} + PW11) &&
          (py_r[i] <= DrawY) && ({1'b0, DrawY} < {1'b0, py_r[i]} + PH11)) begin
        pix_s = 1'b1;
      end else begin
        pix_s = pix_s;
      end
    end
  end

  // Update FSM next-state: each of SCROLL/RESPAWN/CHECK walks all slots.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    state_s = tick_s ? SCROLL : IDLE;
      SCROLL:  state_s = (k_r == LAST_K) ? RESPAWN : SCROLL;
      RESPAWN: state_s = (k_r == LAST_K) ? CHECK : RESPAWN;
      CHECK:   state_s = (k_r == LAST_K) ? DONE : CHECK;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Slot field, LFSR, landing capture and registered outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_clk_q_r <= 1'b0;
      k_r           <= '0;
      shift_r       <= 10'd0;
      ball_x_r      <= 10'd0;
      ball_y_r      <= 10'd0;
      ball_s_r      <= 10'd0;
      ball_f_r      <= 1'b0;
      lfsr_r        <= LFSR_SEED;
      hit_r         <= 1'b0;
      win_y_r       <= 10'd0;
      plat_pixel_r  <= 1'b0;
      land_r        <= 1'b0;
      land_y_r      <= 10'd0;
      scroll_amt_r  <= 10'd0;
      score_r       <= 16'd0;
      for (int i = 0; i < NUM_PLAT; i++) begin
        py_r[i] <= 10'(i * ROW_PITCH);
        px_r[i] <= 10'(72 * i);
      end
    end else begin
      frame_clk_q_r <= frame_clk;
      plat_pixel_r  <= pix_s;
      land_r        <= 1'b0;
      case (state_r)
        IDLE: begin
          k_r   <= '0;
          hit_r <= 1'b0;
          if (tick_s) begin
            ball_x_r <= BallX;
            ball_y_r <= BallY;
            ball_s_r <= BallS;
            ball_f_r <= BallFalling;
            shift_r  <= shift_s;
          end
        end
        SCROLL: begin
          py_r[k_r] <= py_r[k_r] + shift_r;
          k_r       <= (k_r == LAST_K) ? '0 : k_r + 1'b1;
        end
        RESPAWN: begin
          if (py_r[k_r] >= SCR_H) begin
            py_r[k_r] <= py_r[k_r] - SCR_H;
            px_r[k_r] <= rand_x_s;
            lfsr_r    <= lfsr_next(lfsr_r);
          end
          k_r <= (k_r == LAST_K) ? '0 : k_r + 1'b1;
        end
        CHECK: begin
          // First hit in index order wins; later hits leave the capture alone.
          if (hit_k_s && !hit_r) begin
            hit_r   <= 1'b1;
            win_y_r <= py_r[k_r];
          end
          k_r <= (k_r == LAST_K) ? '0 : k_r + 1'b1;
        end
        DONE: begin
          scroll_amt_r <= shift_r;
          score_r      <= sat_add16(score_r, shift_r);
          if (hit_r) begin
            land_r   <= 1'b1;
            land_y_r <= win_y_r;
          end
        end
        default: k_r <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_platform_scroller.sv
// Testbench for platform_scroller: a reference model of the platform field
// predicts each frame's outputs, which are queued at the tick and compared
// when the update finishes; PlatPixel is probed against the model's field.
module tb_platform_scroller;

  logic        Clk = 1'b0;
  logic        Reset, frame_clk, BallFalling;
  logic [9:0]  BallX, BallY, BallS, DrawX, DrawY;
  logic        PlatPixel, Land, Busy;
  logic [9:0]  LandY, ScrollAmt;
  logic [15:0] Score;

  always #5 Clk = ~Clk;

  platform_scroller dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
    .BallX(BallX), .BallY(BallY), .BallS(BallS), .BallFalling(BallFalling),
    .DrawX(DrawX), .DrawY(DrawY), .PlatPixel(PlatPixel), .Land(Land),
    .LandY(LandY), .ScrollAmt(ScrollAmt), .Score(Score), .Busy(Busy)
  );

  typedef struct {
    logic [9:0]  scroll;
    logic [15:0] score;
    logic        land;
    logic [9:0]  land_y;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_py [8];
  int          m_px [8];
  logic [15:0] m_lfsr;
  int          m_score;
  int          m_landy;

  task automatic m_reset();
    for (int i = 0; i < 8; i++) begin
      m_py[i] = i * 60;
      m_px[i] = 72 * i;
    end
    m_lfsr  = 16'hACE1;
    m_score = 0;
    m_landy = 0;
  endtask

  task automatic m_frame(input int bx, input int by, input int bs, input bit bf, output exp_t e);
    int sh, r, bot;
    bit land;
    sh = 0;
    if (by < 160) sh = (160 - by > 16) ? 16 : 160 - by;
    for (int i = 0; i < 8; i++) m_py[i] = m_py[i] + sh;
    for (int i = 0; i < 8; i++) begin
      if (m_py[i] >= 480) begin
        m_py[i] = m_py[i] - 480;
        r = int'(m_lfsr[9:0]);
        while (r >= 576) r = r - 576;
        m_px[i] = r;
        m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
      end
    end
    bot  = by + bs;
    land = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!land && bf && m_py[i] <= bot && bot < m_py[i] + 8 &&
          bx + bs > m_px[i] && bx < m_px[i] + 64 + bs) begin
        land    = 1'b1;
        m_landy = m_py[i];
      end
    end
    m_score  = (m_score + sh > 65535) ? 65535 : m_score + sh;
    e.scroll = 10'(sh);
    e.score  = 16'(m_score);
    e.land   = land;
    e.land_y = 10'(m_landy);
  endtask

  function automatic bit m_pix(input int x, input int y);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 8; i++)
      if (m_py[i] < 480 && m_px[i] <= x && x < m_px[i] + 64 && m_py[i] <= y && y < m_py[i] + 8)
        hit = 1'b1;
    return hit;
  endfunction

  // ---------------- scoreboard monitor ----------------
  logic busy_q     = 1'b0;
  bit   sb_mute    = 1'b0;
  bit   land_watch = 1'b0;

  always @(negedge Clk) begin
    if (!sb_mute && busy_q && !Busy) begin
      if (sb_q.size() == 0) begin
        check_eq("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check_eq("scroll_amt", ScrollAmt, mon_e.scroll);
        check_eq("score", Score, mon_e.score);
        check_eq("land", Land, mon_e.land);
        check_eq("land_y", LandY, mon_e.land_y);
        land_watch = 1'b1;
      end
    end else if (land_watch) begin
      check_eq("land_one_cycle", Land, 1'b0);
      land_watch = 1'b0;
    end
    busy_q = Busy;
  end

  // ---------------- stimulus helpers ----------------
  task automatic probe(input int x, input int y);
    @(negedge Clk);
    DrawX = 10'(x);
    DrawY = 10'(y);
    @(negedge Clk);
    check_eq("plat_pixel", PlatPixel, m_pix(x, y));
  endtask

  task automatic probe_field();
    for (int i = 0; i < 8; i++) begin
      if (m_py[i] < 480) begin
        probe(m_px[i], m_py[i]);
        probe(m_px[i] + 63, m_py[i] + 7);
        probe(m_px[i] + 64, m_py[i]);
      end
    end
    probe($urandom_range(0, 639), $urandom_range(0, 479));
  endtask

  task automatic run_frame(input int bx, input int by, input int bs, input bit bf, input bit retick);
    exp_t e;
    int   cyc;
    @(negedge Clk);
    BallX = 10'(bx); BallY = 10'(by); BallS = 10'(bs); BallFalling = bf;
    m_frame(bx, by, bs, bf, e);
    sb_q.push_back(e);
    frame_clk = 1'b1;
    @(negedge Clk);
    frame_clk = 1'b0;
    // Scramble the ball inputs: the update must work from the latched copy.
    BallX = 10'($urandom_range(0, 1023)); BallY = 10'($urandom_range(0, 1023));
    BallS = 10'($urandom_range(0, 1023)); BallFalling = ~bf;
    cyc = 0;
    while (Busy && cyc < 100) begin
      if (retick && cyc == 5) frame_clk = 1'b1;
      if (retick && cyc == 8) frame_clk = 1'b0;
      @(negedge Clk);
      cyc++;
    end
    check_eq("busy_cycles", cyc, 25);
    @(negedge Clk);
    check_eq("sb_drained", sb_q.size(), 0);
    probe_field();
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    m_reset();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int s;
    Reset = 1'b0; frame_clk = 1'b0; BallFalling = 1'b0;
    BallX = 10'd0; BallY = 10'd300; BallS = 10'd8; DrawX = 10'd0; DrawY = 10'd0;

    // Reset state
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    check_eq("rst_score", Score, 16'd0);
    check_eq("rst_scroll", ScrollAmt, 10'd0);
    check_eq("rst_land", Land, 1'b0);
    check_eq("rst_land_y", LandY, 10'd0);
    check_eq("rst_busy", Busy, 1'b0);
    check_eq("rst_pix", PlatPixel, 1'b0);
    Reset = 1'b0;
    m_reset();

    // Reset layout: slot 3 at (216,180)
    @(negedge Clk); DrawX = 10'd220; DrawY = 10'd182;
    @(negedge Clk); check_eq("t1_pix_on", PlatPixel, 1'b1);
    DrawX = 10'd215;
    @(negedge Clk); check_eq("t1_pix_left", PlatPixel, 1'b0);
    probe_field();

    // Landing on the unscrolled layout (slot 3), then the same while rising
    run_frame(240, 176, 8, 1'b1, 1'b0);
    check_eq("t4_land_y", LandY, 10'd180);
    run_frame(240, 176, 8, 1'b0, 1'b0);

    // Scroll clamp and partial scroll
    run_frame(300, 130, 8, 1'b0, 1'b0);
    check_eq("t2_scroll16", ScrollAmt, 10'd16);
    check_eq("t2_score16", Score, 16'd16);
    probe(0, 16);
    probe(0, 15);
    run_frame(300, 150, 8, 1'b0, 1'b0);
    check_eq("t2_scroll10", ScrollAmt, 10'd10);
    check_eq("t2_score26", Score, 16'd26);

    // Scroll-line boundaries, and a second frame_clk edge during an update
    run_frame(300, 160, 8, 1'b0, 1'b0);
    run_frame(300, 159, 8, 1'b0, 1'b1);
    run_frame(300, 0, 8, 1'b0, 1'b1);

    // Drive the field through a full wrap so every slot respawns
    for (int f = 0; f < 32; f++) run_frame(320, 100 + (f % 5) * 10, 8, 1'b0, (f % 7) == 0);

    // Targeted landing boundaries against a slot below the scroll line
    s = -1;
    for (int i = 7; i >= 0; i--) if (m_py[i] >= 176 && m_py[i] <= 470) s = i;
    if (s >= 0) begin
      run_frame(m_px[s] + 10, m_py[s] - 1, 8, 1'b1, 1'b0);
      run_frame(m_px[s] + 10, m_py[s], 8, 1'b1, 1'b0);
      run_frame(m_px[s] + 63, m_py[s] - 1, 8, 1'b1, 1'b0);
      run_frame(m_px[s] + 72, m_py[s] - 1, 8, 1'b1, 1'b0);
      if (m_px[s] >= 8) run_frame(m_px[s] - 8, m_py[s] - 1, 8, 1'b1, 1'b0);
    end

    // Random frames
    for (int f = 0; f < 20; f++)
      run_frame($urandom_range(0, 639), $urandom_range(0, 479), $urandom_range(1, 16),
                1'($urandom_range(0, 1)), 1'b0);

    // Score saturation
    @(negedge Clk);
    force dut.score_r = 16'hFFF8;
    @(negedge Clk);
    release dut.score_r;
    m_score = 16'hFFF8;
    run_frame(300, 100, 8, 1'b0, 1'b0);
    check_eq("t5_sat", Score, 16'hFFFF);
    run_frame(300, 120, 8, 1'b0, 1'b0);

    // Reset in the middle of an update (RESPAWN phase)
    @(negedge Clk);
    BallX = 10'd240; BallY = 10'd100; BallS = 10'd8; BallFalling = 1'b1;
    sb_mute = 1'b1;
    frame_clk = 1'b1;
    @(negedge Clk);
    frame_clk = 1'b0;
    check_eq("t6_busy_started", Busy, 1'b1);
    repeat (11) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    check_eq("t6_busy", Busy, 1'b0);
    check_eq("t6_land", Land, 1'b0);
    check_eq("t6_score", Score, 16'd0);
    check_eq("t6_scroll", ScrollAmt, 10'd0);
    m_reset();
    s = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge Clk);
      if (Land || Busy) s++;
    end
    check_eq("t6_quiet", s, 0);
    sb_mute = 1'b0;
    probe_field();
    run_frame(240, 176, 8, 1'b1, 1'b0);
    run_frame(300, 140, 8, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
